// File: rtl/bids22_pkg.sv
// Shared types and constants for the bids22 auction unit, its host sequencer and the bench.
package bids22_pkg;

  typedef enum logic [3:0] {
    OP_NOOP         = 4'd0,
    OP_UNLOCK       = 4'd1,
    OP_LOCK         = 4'd2,
    OP_LOAD_X       = 4'd3,
    OP_LOAD_Y       = 4'd4,
    OP_LOAD_Z       = 4'd5,
    OP_SET_XYZ_MASK = 4'd6,
    OP_SET_TIMER    = 4'd7,
    OP_BID_CHARGE   = 4'd8
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CFG    = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    UNLOCK = 3'd4,
    REPORT = 3'd5
  } ctrl_state_t;

  localparam logic [2:0] ERR_NONE      = 3'b000;
  localparam logic [2:0] ERR_DUP       = 3'b101;
  localparam logic [2:0] ERR_TIMEOUT   = 3'b111;
  localparam logic [2:0] CFG_LAST_STEP = 3'd6;

  // Session setup order; Lock goes last so the unit is only locked once fully configured.
  function automatic opcode_t cfg_step_op(input logic [2:0] step);
    opcode_t op;
    case (step)
      3'd0:    op = OP_LOAD_X;
      3'd1:    op = OP_LOAD_Y;
      3'd2:    op = OP_LOAD_Z;
      3'd3:    op = OP_SET_XYZ_MASK;
      3'd4:    op = OP_SET_TIMER;
      3'd5:    op = OP_BID_CHARGE;
      3'd6:    op = OP_LOCK;
      default: op = OP_NOOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/bids22_round_timer.sv
// Loadable down counter; holds at zero and flags terminal count.
module bids22_round_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bids22_round_ctrl.sv
// Host-side session sequencer for the bids22 auction unit: configure, lock, run one timed
// round, capture the result, unlock, and hold the report until consumed.
//
// state  | meaning
// IDLE   | waiting for a session request (cfg_ready=1)
// CFG    | issuing the seven setup ops, ending with Lock
// RUN    | C_start held high for the round length
// DRAIN  | waiting up to DRAIN_MAX cycles for roundOver
// UNLOCK | issuing Unlock with the key
// REPORT | result held on res_* until res_ready
module bids22_round_ctrl
  import bids22_pkg::*;
#(
  parameter logic [31:0] KEY       = 32'h0F0F0F0F,
  parameter int          LEN_W     = 16,
  parameter int          DRAIN_MAX = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [31:0]      cfg_x_fund,
  input  logic [31:0]      cfg_y_fund,
  input  logic [31:0]      cfg_z_fund,
  input  logic [2:0]       cfg_mask,
  input  logic [31:0]      cfg_timer,
  input  logic [31:0]      cfg_cost,
  input  logic [LEN_W-1:0] cfg_len,
  output logic [3:0]       C_op,
  output logic [31:0]      C_data,
  output logic             C_start,
  input  logic             ready,
  input  logic [2:0]       err,
  input  logic             roundOver,
  input  logic [31:0]      maxBid,
  input  logic             X_win,
  input  logic             Y_win,
  input  logic             Z_win,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       res_win,
  output logic [31:0]      res_max,
  output logic [2:0]       res_err,
  output logic             busy
);

  localparam int DRAIN_W = $clog2(DRAIN_MAX + 1);

  ctrl_state_t state, state_d;
  logic [2:0]  step, step_d, sel_step;
  logic        op_vld, op_vld_d;
  opcode_t     c_op_q, c_op_d, tbl_op;
  logic [31:0] c_data_d, tbl_data;
  logic        c_start_d, res_valid_d;
  logic [2:0]  res_win_d, res_err_d;
  logic [31:0] res_max_d;
  logic        cfg_latch;
  logic        rt_load, rt_en, rt_zero;
  logic        dt_load, dt_en, dt_zero;

  logic [31:0]      fund_x_r, fund_y_r, fund_z_r, timer_r, cost_r;
  logic [2:0]       mask_r;
  logic [LEN_W-1:0] len_r, rt_load_val;

  // op_vld marks that C_op already carries the op for 'step', so the table looks one ahead.
  assign sel_step    = op_vld ? (step + 3'd1) : step;
  assign tbl_op      = cfg_step_op(sel_step);
  assign rt_load_val = (len_r == '0) ? '0 : (len_r - LEN_W'(1));
  assign C_op        = c_op_q;

  always_comb begin
    tbl_data = '0;
    case (sel_step)
      3'd0:    tbl_data = fund_x_r;
      3'd1:    tbl_data = fund_y_r;
      3'd2:    tbl_data = fund_z_r;
      3'd3:    tbl_data = {29'b0, mask_r};
      3'd4:    tbl_data = timer_r;
      3'd5:    tbl_data = cost_r;
      3'd6:    tbl_data = KEY;
      default: tbl_data = '0;
    endcase
  end

  bids22_round_timer #(.W(LEN_W)) u_round_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (rt_load),
    .load_val (rt_load_val),
    .en       (rt_en),
    .zero     (rt_zero)
  );

  bids22_round_timer #(.W(DRAIN_W)) u_drain_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (dt_load),
    .load_val (DRAIN_W'(DRAIN_MAX - 1)),
    .en       (dt_en),
    .zero     (dt_zero)
  );

  always_comb begin
    state_d     = state;
    step_d      = step;
    op_vld_d    = op_vld;
    c_op_d      = c_op_q;
    c_data_d    = C_data;
    c_start_d   = C_start;
    res_valid_d = res_valid;
    res_win_d   = res_win;
    res_max_d   = res_max;
    res_err_d   = res_err;
    cfg_latch   = 1'b0;
    rt_load     = 1'b0;
    rt_en       = 1'b0;
    dt_load     = 1'b0;
    dt_en       = 1'b0;

    case (state)
      IDLE: begin
        if (cfg_valid) begin
          cfg_latch = 1'b1;
          step_d    = 3'd0;
          op_vld_d  = 1'b0;
          state_d   = CFG;
        end
      end
      CFG: begin
        if (!op_vld) begin
          c_op_d   = tbl_op;
          c_data_d = tbl_data;
          op_vld_d = 1'b1;
        end else if (ready) begin
          if (err != ERR_NONE) begin
            c_op_d      = OP_NOOP;
            c_data_d    = '0;
            res_err_d   = err;
            res_win_d   = '0;
            res_max_d   = '0;
            res_valid_d = 1'b1;
            op_vld_d    = 1'b0;
            state_d     = REPORT;
          end else if (step == CFG_LAST_STEP) begin
            c_op_d    = OP_NOOP;
            c_data_d  = '0;
            c_start_d = 1'b1;
            rt_load   = 1'b1;
            op_vld_d  = 1'b0;
            state_d   = RUN;
          end else begin
            step_d   = step + 3'd1;
            c_op_d   = tbl_op;
            c_data_d = tbl_data;
          end
        end
      end
      RUN: begin
        if (rt_zero) begin
          c_start_d = 1'b0;
          dt_load   = 1'b1;
          state_d   = DRAIN;
        end else begin
          rt_en = 1'b1;
        end
      end
      DRAIN: begin
        // roundOver is tested first so it wins over a timeout expiring in the same cycle.
        if (roundOver) begin
          res_win_d = {Z_win, Y_win, X_win};
          res_max_d = maxBid;
          res_err_d = err;
          c_op_d    = OP_UNLOCK;
          c_data_d  = KEY;
          state_d   = UNLOCK;
        end else if (dt_zero) begin
          res_win_d = '0;
          res_max_d = '0;
          res_err_d = ERR_TIMEOUT;
          c_op_d    = OP_UNLOCK;
          c_data_d  = KEY;
          state_d   = UNLOCK;
        end else begin
          dt_en = 1'b1;
        end
      end
      UNLOCK: begin
        if (ready) begin
          c_op_d      = OP_NOOP;
          c_data_d    = '0;
          res_valid_d = 1'b1;
          state_d     = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      step      <= 3'd0;
      op_vld    <= 1'b0;
      c_op_q    <= OP_NOOP;
      C_data    <= '0;
      C_start   <= 1'b0;
      res_valid <= 1'b0;
      res_win   <= '0;
      res_max   <= '0;
      res_err   <= '0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      step      <= step_d;
      op_vld    <= op_vld_d;
      c_op_q    <= c_op_d;
      C_data    <= c_data_d;
      C_start   <= c_start_d;
      res_valid <= res_valid_d;
      res_win   <= res_win_d;
      res_max   <= res_max_d;
      res_err   <= res_err_d;
      cfg_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fund_x_r <= '0;
      fund_y_r <= '0;
      fund_z_r <= '0;
      mask_r   <= '0;
      timer_r  <= '0;
      cost_r   <= '0;
      len_r    <= '0;
    end else if (cfg_latch) begin
      fund_x_r <= cfg_x_fund;
      fund_y_r <= cfg_y_fund;
      fund_z_r <= cfg_z_fund;
      mask_r   <= cfg_mask;
      timer_r  <= cfg_timer;
      cost_r   <= cfg_cost;
      len_r    <= cfg_len;
    end
  end

endmodule

// File: tb/tb_bids22_round_ctrl.sv
// Scoreboard bench for bids22_round_ctrl: directed sessions, queued expected ops/results.
module tb_bids22_round_ctrl;
  import bids22_pkg::*;

  localparam logic [31:0] KEY = 32'h0F0F0F0F;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_x_fund = '0, cfg_y_fund = '0, cfg_z_fund = '0;
  logic [2:0]  cfg_mask = '0;
  logic [31:0] cfg_timer = '0, cfg_cost = '0;
  logic [15:0] cfg_len = '0;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start;
  logic        ready = 1'b1;
  logic [2:0]  err;
  logic        roundOver = 1'b0;
  logic [31:0] maxBid = '0;
  logic        X_win = 1'b0, Y_win = 1'b0, Z_win = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [2:0]  res_win;
  logic [31:0] res_max;
  logic [2:0]  res_err;
  logic        busy;

  logic [3:0]  inj_op = 4'd0;
  logic [2:0]  inj_code = 3'd0;
  logic [2:0]  rnd_err = 3'd0;

  // Auction unit model: err is combinational on C_op, optionally injected on one opcode.
  assign err = ((inj_op != 4'd0) && (C_op == inj_op)) ? inj_code : rnd_err;

  bids22_round_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_x_fund(cfg_x_fund), .cfg_y_fund(cfg_y_fund), .cfg_z_fund(cfg_z_fund),
    .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_cost(cfg_cost), .cfg_len(cfg_len),
    .C_op(C_op), .C_data(C_data), .C_start(C_start),
    .ready(ready), .err(err), .roundOver(roundOver), .maxBid(maxBid),
    .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_win(res_win), .res_max(res_max), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [3:0] op; logic [31:0] data;} op_exp_t;
  typedef struct packed {logic [2:0] win; logic [31:0] max; logic [2:0] err;} res_exp_t;
  op_exp_t  exp_ops[$];
  res_exp_t exp_res[$];
  op_exp_t  op_e;
  res_exp_t res_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Op monitor: every op accepted by the unit (ready high at the next edge) is scoreboarded.
  always @(negedge clk) begin
    if (reset_n && (C_op != 4'd0) && ready) begin
      if (exp_ops.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL op_unexpected actual=%0d required=none", C_op);
      end else begin
        op_e = exp_ops.pop_front();
        chk("op_code", {28'b0, C_op}, {28'b0, op_e.op});
        chk("op_data", C_data, op_e.data);
      end
    end
  end

  // Result monitor: compares on the res_valid & res_ready handshake.
  always @(negedge clk) begin
    if (reset_n && res_valid && res_ready) begin
      if (exp_res.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected actual=%0h required=none", res_err);
      end else begin
        res_e = exp_res.pop_front();
        chk("res_win", {29'b0, res_win}, {29'b0, res_e.win});
        chk("res_max", res_max, res_e.max);
        chk("res_err", {29'b0, res_err}, {29'b0, res_e.err});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_cfg(input logic [31:0] fx, fy, fz, input logic [2:0] m,
                          input logic [31:0] t, c, input logic with_lock);
    exp_ops.push_back('{op: 4'd3, data: fx});
    exp_ops.push_back('{op: 4'd4, data: fy});
    exp_ops.push_back('{op: 4'd5, data: fz});
    exp_ops.push_back('{op: 4'd6, data: {29'b0, m}});
    exp_ops.push_back('{op: 4'd7, data: t});
    if (with_lock) begin
      exp_ops.push_back('{op: 4'd8, data: c});
      exp_ops.push_back('{op: 4'd2, data: KEY});
    end
  endtask

  task automatic start_session(input logic [31:0] fx, fy, fz, input logic [2:0] m,
                               input logic [31:0] t, c, input logic [15:0] l);
    cfg_x_fund = fx; cfg_y_fund = fy; cfg_z_fund = fz;
    cfg_mask = m; cfg_timer = t; cfg_cost = c; cfg_len = l;
    cfg_valid = 1'b1;
    cyc(1);
    cfg_valid = 1'b0;
  endtask

  task automatic count_start(input int window, output int n_hi);
    bit seen;
    seen = 1'b0;
    n_hi = 0;
    for (int g = 0; g < window; g++) begin
      @(negedge clk);
      if (C_start) begin
        n_hi++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    for (int g = 0; g < 60; g++) begin
      @(negedge clk);
      if (cfg_ready) break;
    end
    chk(name, {31'b0, cfg_ready}, 32'd1);
  endtask

  logic [3:0]  seq_op [7];
  logic [31:0] seq_dat[7];
  int n;
  int d;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(3);
    chk("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    chk("rst_busy",      {31'b0, busy}, 32'd0);
    chk("rst_c_op",      {28'b0, C_op}, 32'd0);
    chk("rst_c_data",    C_data, 32'd0);
    chk("rst_c_start",   {31'b0, C_start}, 32'd0);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_res_win",   {29'b0, res_win}, 32'd0);
    chk("rst_res_max",   res_max, 32'd0);
    chk("rst_res_err",   {29'b0, res_err}, 32'd0);
    reset_n = 1'b1;
    cyc(2);

    // Normal session with explicit op sequence and latency
    seq_op  = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
    seq_dat = '{32'd100, 32'd100, 32'd100, 32'd7, 32'd50, 32'd1, KEY};
    push_cfg(100, 100, 100, 3'b111, 50, 1, 1'b1);
    exp_ops.push_back('{op: 4'd1, data: KEY});
    exp_res.push_back('{win: 3'b010, max: 32'd20, err: 3'b000});
    res_ready = 1'b0;
    start_session(100, 100, 100, 3'b111, 50, 1, 16'd4);
    chk("lat_noop_first", {28'b0, C_op}, 32'd0);
    for (int k = 0; k < 7; k++) begin
      cyc(1);
      chk("seq_op", {28'b0, C_op}, {28'b0, seq_op[k]});
      chk("seq_data", C_data, seq_dat[k]);
    end
    count_start(60, n);
    chk("run_len4", n, 32'd4);
    chk("drain_busy", {31'b0, busy}, 32'd1);
    chk("drain_cfg_ready", {31'b0, cfg_ready}, 32'd0);
    cfg_valid = 1'b1;
    cyc(1);
    cfg_valid = 1'b0;
    roundOver = 1'b1; Y_win = 1'b1; maxBid = 32'd20;
    cyc(1);
    roundOver = 1'b0; Y_win = 1'b0; maxBid = '0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    cyc(3);
    chk("hold_res_valid", {31'b0, res_valid}, 32'd1);
    chk("hold_res_win", {29'b0, res_win}, 32'd2);
    res_ready = 1'b1;
    wait_idle("normal_idle");
    cyc(2);
    chk("ignored_cfg_idle", {31'b0, cfg_ready}, 32'd1);

    // Stall during LoadY, then a duplicate-error result
    push_cfg(11, 22, 33, 3'b101, 9, 2, 1'b1);
    exp_ops.push_back('{op: 4'd1, data: KEY});
    exp_res.push_back('{win: 3'b000, max: 32'd7, err: ERR_DUP});
    start_session(11, 22, 33, 3'b101, 9, 2, 16'd1);
    cyc(2);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("stall_op", {28'b0, C_op}, 32'd4);
      chk("stall_data", C_data, 32'd22);
    end
    ready = 1'b1;
    cyc(1);
    chk("stall_resume", {28'b0, C_op}, 32'd5);
    count_start(60, n);
    chk("run_len1", n, 32'd1);
    cyc(1);
    rnd_err = ERR_DUP; roundOver = 1'b1; maxBid = 32'd7;
    cyc(1);
    rnd_err = 3'd0; roundOver = 1'b0; maxBid = '0;
    wait_idle("dup_idle");

    // Abort on SetTimer error
    inj_op = 4'd7; inj_code = 3'b100;
    push_cfg(1, 2, 3, 3'b011, 77, 5, 1'b0);
    exp_res.push_back('{win: 3'b000, max: 32'd0, err: 3'b100});
    start_session(1, 2, 3, 3'b011, 77, 5, 16'd3);
    count_start(40, n);
    chk("abort_no_start", n, 32'd0);
    wait_idle("abort_idle");
    chk("abort_c_op", {28'b0, C_op}, 32'd0);
    inj_op = 4'd0; inj_code = 3'd0;

    // Timeout with len 0; roundOver during CFG must be ignored
    push_cfg(5, 6, 7, 3'b110, 12, 3, 1'b1);
    exp_ops.push_back('{op: 4'd1, data: KEY});
    exp_res.push_back('{win: 3'b000, max: 32'd0, err: ERR_TIMEOUT});
    start_session(5, 6, 7, 3'b110, 12, 3, 16'd0);
    roundOver = 1'b1; X_win = 1'b1; maxBid = 32'd99;
    cyc(1);
    roundOver = 1'b0; X_win = 1'b0; maxBid = '0;
    count_start(60, n);
    chk("run_len0", n, 32'd1);
    d = 0;
    for (int g = 0; g < 20; g++) begin
      if (C_op == 4'd1) break;
      d++;
      @(negedge clk);
    end
    chk("drain_cycles", d, 32'd8);
    wait_idle("timeout_idle");

    // Asynchronous reset in the middle of RUN
    push_cfg(40, 41, 42, 3'b111, 8, 1, 1'b1);
    start_session(40, 41, 42, 3'b111, 8, 1, 16'd20);
    for (int g = 0; g < 30; g++) begin
      @(negedge clk);
      if (C_start) break;
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_c_start", {31'b0, C_start}, 32'd0);
    chk("arst_c_op", {28'b0, C_op}, 32'd0);
    chk("arst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("arst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    chk("post_rst_idle", {31'b0, cfg_ready}, 32'd1);

    chk("ops_drained", exp_ops.size(), 32'd0);
    chk("res_drained", exp_res.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
